// File: rtl/snake_pkg.sv
// snake_pkg: shared state encoding, direction codes, grid constants and position
// helpers for the snake game sequencer and its segment scanner.
package snake_pkg;

    localparam int         GRID_W     = 16;
    localparam logic [3:0] GRID_MAX   = 4'(GRID_W - 1);
    localparam logic [3:0] LEN_INIT   = 4'd3;
    localparam logic [7:0] APPLE_INIT = 8'h88;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_STEP,
        S_SETTLE,
        S_PLACE,
        S_OVER
    } snake_state_e;

    function automatic logic [3:0] pos_x(input logic [7:0] p);
        return p[3:0];
    endfunction

    function automatic logic [3:0] pos_y(input logic [7:0] p);
        return p[7:4];
    endfunction

    function automatic logic [7:0] pos_make(input logic [3:0] x, input logic [3:0] y);
        return {y, x};
    endfunction

    // The encoding is chosen so that the opposite direction is the bitwise inverse.
    function automatic logic [1:0] dir_reverse(input logic [1:0] d);
        return ~d;
    endfunction

endpackage

// File: rtl/snake_seg_scan.sv
// snake_seg_scan: serial comparator that walks segments 0..count-1 of the snake bus,
// one per cycle, against a latched key; done pulses on the first hit or the last segment.
module snake_seg_scan
    import snake_pkg::*;
#(
    parameter int SEG_N = 9,
    parameter int POS_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [POS_W-1:0]       key_i,
    input  logic [3:0]             count_i,
    input  logic [SEG_N*POS_W-1:0] snake_i,
    output logic                   done_o,
    output logic                   hit_o
);

    logic [POS_W-1:0] seg [16];
    logic             busy_q;
    logic [3:0]       idx_q;
    logic [3:0]       cnt_q;
    logic [POS_W-1:0] key_q;
    logic             match;
    logic             last;

    // Pad the bus out to 16 slots so a 4-bit index never selects past the array.
    for (genvar g = 0; g < 16; g++) begin : g_seg
        if (g < SEG_N) begin : g_live
            assign seg[g] = snake_i[g*POS_W +: POS_W];
        end else begin : g_pad
            assign seg[g] = '0;
        end
    end

    assign match  = busy_q && (seg[idx_q] == key_q);
    assign last   = busy_q && ((cnt_q == 4'd0) || (idx_q == cnt_q - 4'd1));
    assign hit_o  = match;
    assign done_o = match || last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            idx_q  <= 4'd0;
            cnt_q  <= 4'd0;
            key_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            idx_q  <= 4'd0;
            cnt_q  <= count_i;
            key_q  <= key_i;
        end else if (done_o) begin
            busy_q <= 1'b0;
        end else if (busy_q) begin
            idx_q  <= idx_q + 4'd1;
        end
    end

endmodule

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: snake game sequencer (game state, move tick, direction latch,
// self-collision, apple placement, score). Define SNAKE_WRAP_EN for a toroidal grid.
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 7_500_000,
    parameter int SEG_N    = 9,
    parameter int POS_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up,
    input  logic                   right,
    input  logic                   left,
    input  logic                   down,
    input  logic [POS_W-1:0]       random_num,
    input  logic [SEG_N*POS_W-1:0] snake,
    output logic                   step,
    output logic                   grow,
    output logic [POS_W-1:0]       next_head,
    output logic [1:0]             dir,
    output logic [3:0]             len,
    output logic [POS_W-1:0]       apple,
    output logic                   apple_valid,
    output logic [3:0]             score,
    output logic                   game_over
);

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam int               TICK_W      = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);
    localparam logic [3:0]       SEG_LIM     = 4'(SEG_N);

    function automatic logic [3:0] score_sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    snake_state_e     state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q;
    logic             tick_pend_q;
    logic             tick_now;
    logic             tick_take;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       dir_cur_q, dir_cur_d;
    logic [1:0]       dir_req;
    logic [3:0]       btn;
    logic [3:0]       btn_prev_q;
    logic             any_btn;
    logic             any_rise;
    logic [POS_W-1:0] nh_q, nh_d;
    logic             ate_q, ate_d;
    logic [3:0]       len_q, len_d;
    logic [3:0]       score_q, score_d;
    logic [POS_W-1:0] apple_q, apple_d;
    logic             apple_vld_q, apple_vld_d;
    logic [POS_W-1:0] cand_q, cand_d;
    logic [3:0]       hx, hy, nx, ny;
    logic             wall_raw, wall_hit;
    logic [POS_W-1:0] nh_calc;
    logic             ate_calc;
    logic             scan_start;
    logic [POS_W-1:0] scan_key;
    logic [3:0]       scan_cnt;
    logic             scan_done;
    logic             scan_hit;

    snake_seg_scan #(
        .SEG_N (SEG_N),
        .POS_W (POS_W)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .start_i (scan_start),
        .key_i   (scan_key),
        .count_i (scan_cnt),
        .snake_i (snake),
        .done_o  (scan_done),
        .hit_o   (scan_hit)
    );

    assign btn      = {up, right, left, down};
    assign any_btn  = |btn;
    assign any_rise = |(btn & ~btn_prev_q);
    assign tick_now = (tick_cnt_q == '0);

    // Direction latch: highest-priority button wins, a reversal of the in-flight move is dropped.
    always_comb begin
        dir_req = DIR_DOWN;
        if (up)         dir_req = DIR_UP;
        else if (right) dir_req = DIR_RIGHT;
        else if (left)  dir_req = DIR_LEFT;
        dir_d = dir_q;
        if (any_btn && (state_q != S_OVER) && (dir_req != dir_reverse(dir_cur_q)))
            dir_d = dir_req;
    end

    always_comb begin
        hx       = pos_x(snake[POS_W-1:0]);
        hy       = pos_y(snake[POS_W-1:0]);
        nx       = hx;
        ny       = hy;
        wall_raw = 1'b0;
        case (dir_q)
            DIR_UP:    begin ny = hy - 4'd1; wall_raw = (hy == 4'd0);     end
            DIR_RIGHT: begin nx = hx + 4'd1; wall_raw = (hx == GRID_MAX); end
            DIR_LEFT:  begin nx = hx - 4'd1; wall_raw = (hx == 4'd0);     end
            default:   begin ny = hy + 4'd1; wall_raw = (hy == GRID_MAX); end
        endcase
        nh_calc  = pos_make(nx, ny);
        wall_hit = !WRAP_EN && wall_raw;
        ate_calc = apple_vld_q && (nh_calc == apple_q);
    end

    always_comb begin
        state_d     = state_q;
        dir_cur_d   = dir_cur_q;
        nh_d        = nh_q;
        ate_d       = ate_q;
        len_d       = len_q;
        score_d     = score_q;
        apple_d     = apple_q;
        apple_vld_d = apple_vld_q;
        cand_d      = cand_q;
        tick_take   = 1'b0;
        scan_start  = 1'b0;
        scan_key    = random_num;
        scan_cnt    = len_q;
        case (state_q)
            S_IDLE: begin
                if (any_btn) begin
                    state_d     = S_PLACE;
                    score_d     = 4'd0;
                    len_d       = LEN_INIT;
                    apple_vld_d = 1'b0;
                    cand_d      = random_num;
                    scan_start  = 1'b1;
                    scan_cnt    = LEN_INIT;
                end
            end
            S_WAIT: begin
                if (tick_pend_q) begin
                    tick_take = 1'b1;
                    dir_cur_d = dir_q;
                    if (wall_hit) begin
                        state_d = S_OVER;
                    end else begin
                        state_d    = S_CHECK;
                        nh_d       = nh_calc;
                        ate_d      = ate_calc;
                        scan_start = 1'b1;
                        scan_key   = nh_calc;
                        // The tail vacates its cell unless this move grows the snake.
                        scan_cnt   = ate_calc ? len_q : len_q - 4'd1;
                    end
                end
            end
            S_CHECK: begin
                if (scan_done)
                    state_d = scan_hit ? S_OVER : S_STEP;
            end
            S_STEP: begin
                if (ate_q) begin
                    score_d     = score_sat_inc(score_q);
                    apple_vld_d = 1'b0;
                    if (len_q < SEG_LIM)
                        len_d = len_q + 4'd1;
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_SETTLE: begin
                state_d    = S_PLACE;
                cand_d     = random_num;
                scan_start = 1'b1;
            end
            S_PLACE: begin
                if (scan_done) begin
                    if (scan_hit) begin
                        cand_d     = random_num;
                        scan_start = 1'b1;
                    end else begin
                        apple_d     = cand_q;
                        apple_vld_d = 1'b1;
                        state_d     = S_WAIT;
                    end
                end
            end
            S_OVER: begin
                if (any_rise)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= TICK_RELOAD;
            tick_pend_q <= 1'b0;
            dir_q       <= DIR_RIGHT;
            dir_cur_q   <= DIR_RIGHT;
            btn_prev_q  <= 4'd0;
            nh_q        <= '0;
            ate_q       <= 1'b0;
            len_q       <= LEN_INIT;
            score_q     <= 4'd0;
            apple_q     <= APPLE_INIT;
            apple_vld_q <= 1'b0;
            cand_q      <= '0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_now ? TICK_RELOAD : tick_cnt_q - TICK_W'(1);
            tick_pend_q <= tick_now || (tick_pend_q && !tick_take);
            dir_q       <= dir_d;
            dir_cur_q   <= dir_cur_d;
            btn_prev_q  <= btn;
            nh_q        <= nh_d;
            ate_q       <= ate_d;
            len_q       <= len_d;
            score_q     <= score_d;
            apple_q     <= apple_d;
            apple_vld_q <= apple_vld_d;
            cand_q      <= cand_d;
        end
    end

    assign step        = (state_q == S_STEP);
    assign grow        = step && ate_q && (len_q < SEG_LIM);
    assign next_head   = nh_q;
    assign dir         = dir_q;
    assign len         = len_q;
    assign apple       = apple_q;
    assign apple_valid = apple_vld_q;
    assign score       = score_q;
    assign game_over   = (state_q == S_OVER);

endmodule
